// File: rtl/game_pkg.sv
// Shared types and constants for the word-scramble game sequencer:
// FSM state encoding, display page codes, BCD width helper, mode display offset.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_PLAY   = 3'd2,
        S_OVER   = 3'd3,
        S_LOGOUT = 3'd4,
        S_TOP    = 3'd5
    } state_t;

    localparam logic [2:0] CTRL_IDLE  = 3'd0;
    localparam logic [2:0] CTRL_SETUP = 3'd1;
    localparam logic [2:0] CTRL_GAME  = 3'd2;
    localparam logic [2:0] CTRL_OVER  = 3'd3;
    localparam logic [2:0] CTRL_TOP0  = 3'd4;
    localparam logic [2:0] CTRL_TOP1  = 3'd5;

    localparam int DEF_MODE_DISP_OFS = 4;

    // Bit width of a BCD vector holding the given number of digits.
    function automatic int bcdVecW(input int digits);
        return 4 * digits;
    endfunction

endpackage

// File: rtl/game_controller_gen_bcd_counter.sv
// Multi-digit saturating BCD incrementer. Adds step (1 or 2) per inc;
// any carry out of the top digit pins the value at all nines.
module bcd_counter #(
    parameter int SCORE_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    input  logic [1:0]                step,
    output logic [4*SCORE_DIGITS-1:0] value,
    output logic [4*SCORE_DIGITS-1:0] nextValue,
    output logic                      all_nines
);

    localparam logic [4*SCORE_DIGITS-1:0] NINES = {SCORE_DIGITS{4'h9}};

    logic [4*SCORE_DIGITS-1:0] sumVec;
    logic [1:0]                carry;
    logic [4:0]                digSum;

    assign all_nines = (value == NINES);

    // Ripple the step through the digits, then saturate on overflow.
    always_comb begin
        sumVec = value;
        carry  = step;
        digSum = '0;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            digSum = {1'b0, value[4*d +: 4]} + {3'b000, carry};
            if (digSum > 5'd9) begin
                digSum = digSum - 5'd10;
                carry  = 2'd1;
            end else begin
                carry  = 2'd0;
            end
            sumVec[4*d +: 4] = digSum[3:0];
        end
        if (!inc || all_nines) begin
            nextValue = value;
        end else if (carry != 2'd0) begin
            nextValue = NINES;
        end else begin
            nextValue = sumVec;
        end
    end

    // Score register; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else begin
            value <= nextValue;
        end
    end

endmodule

// File: rtl/game_controller_gen.sv
// Session/game sequencer: login, mode select, play, game over, logout and
// paged top-score view, with a per-mode best-score table.
// Optional: define GAME_STREAK_BONUS_EN to score +2 from the third
// consecutive solve in a round onward.
module game_controller_gen
    import game_pkg::*;
#(
    parameter int NUM_MODES     = 3,
    parameter int SCORE_DIGITS  = 2,
    parameter int PID_W         = 3,
    parameter int IDX_W         = 3,
    parameter int MODE_DISP_OFS = DEF_MODE_DISP_OFS,
    localparam int MODE_W       = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int BW           = bcdVecW(SCORE_DIGITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              log_on,
    input  logic              pwd_pls,
    input  logic              start_pls,
    input  logic              load_pls,
    input  logic              is_correct,
    input  logic              time_out,
    input  logic [PID_W-1:0]  pid_in,
    input  logic              is_guest_in,
    input  logic [IDX_W-1:0]  ind_in1,
    input  logic [IDX_W-1:0]  ind_in2,
    output logic [2:0]        ctrl_sig,
    output logic              log_out,
    output logic [PID_W-1:0]  pid_out,
    output logic              is_guest_out,
    output logic [BW-1:0]     score_bcd,
    output logic [BW-1:0]     best_bcd,
    output logic              new_best,
    output logic [MODE_W-1:0] lett_num,
    output logic [3:0]        mode_disp,
    output logic              scram_pls,
    output logic              flip_pls,
    output logic [IDX_W-1:0]  ind_out1,
    output logic [IDX_W-1:0]  ind_out2,
    output logic              timer_en,
    output logic              timer_reconfig
);

    localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);
    localparam logic [3:0]        DISP_OFS = 4'(MODE_DISP_OFS);

    state_t            state;
    logic [MODE_W-1:0] mode;
    logic [MODE_W-1:0] modeInc;
    logic              page;
    logic [MODE_W-1:0] pageIdx;
    logic [BW-1:0]     best [NUM_MODES];
    logic [BW-1:0]     scoreNext;
    logic              scoreInc;
    logic              scoreNines;
    logic [1:0]        step;

    assign modeInc  = mode + 1'b1;
    assign scoreInc = (state == S_PLAY) && is_correct;
    assign pageIdx  = (MODE_W'(page) > MODE_MAX) ? MODE_MAX : MODE_W'(page);

`ifdef GAME_STREAK_BONUS_EN
    logic [1:0] streak;

    // Consecutive-solve counter for the current round; a flip without a solve breaks it.
    always_ff @(posedge clk) begin
        if (rst || state != S_PLAY) begin
            streak <= 2'd0;
        end else if (is_correct) begin
            streak <= (streak == 2'd3) ? 2'd3 : streak + 2'd1;
        end else if (load_pls) begin
            streak <= 2'd0;
        end
    end

    assign step = (streak >= 2'd2) ? 2'd2 : 2'd1;
`else
    assign step = 2'd1;
`endif

    bcd_counter #(
        .SCORE_DIGITS(SCORE_DIGITS)
    ) uScore (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == S_IDLE),
        .inc      (scoreInc),
        .step     (step),
        .value    (score_bcd),
        .nextValue(scoreNext),
        .all_nines(scoreNines)
    );

    // Session FSM with registered outputs and the best-score table.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            mode           <= '0;
            page           <= 1'b0;
            ctrl_sig       <= CTRL_IDLE;
            log_out        <= 1'b0;
            pid_out        <= '0;
            is_guest_out   <= 1'b0;
            new_best       <= 1'b0;
            lett_num       <= '0;
            mode_disp      <= '0;
            timer_en       <= 1'b0;
            timer_reconfig <= 1'b1;
            for (int m = 0; m < NUM_MODES; m++) begin
                best[m] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    ctrl_sig       <= CTRL_IDLE;
                    timer_en       <= 1'b0;
                    timer_reconfig <= 1'b1;
                    mode           <= '0;
                    mode_disp      <= '0;
                    log_out        <= 1'b0;
                    new_best       <= 1'b0;
                    if (log_on) begin
                        state          <= S_SETUP;
                        ctrl_sig       <= CTRL_SETUP;
                        timer_reconfig <= 1'b0;
                        mode_disp      <= DISP_OFS;
                    end
                end
                S_SETUP: begin
                    if (pwd_pls) begin
                        log_out  <= 1'b1;
                        state    <= S_LOGOUT;
                        ctrl_sig <= CTRL_IDLE;
                    end else if (load_pls) begin
                        if (mode < MODE_MAX) begin
                            mode      <= modeInc;
                            mode_disp <= 4'(modeInc) + DISP_OFS;
                        end else begin
                            mode      <= '0;
                            mode_disp <= DISP_OFS;
                            page      <= 1'b0;
                            state     <= S_TOP;
                            ctrl_sig  <= CTRL_TOP0;
                        end
                    end else if (start_pls) begin
                        lett_num <= mode;
                        timer_en <= 1'b1;
                        new_best <= 1'b0;
                        state    <= S_PLAY;
                        ctrl_sig <= CTRL_GAME;
                    end
                end
                S_PLAY: begin
                    if (time_out) begin
                        state        <= S_OVER;
                        ctrl_sig     <= CTRL_OVER;
                        timer_en     <= 1'b0;
                        pid_out      <= pid_in;
                        is_guest_out <= is_guest_in;
                        if (!is_guest_in && scoreNext > best[mode]) begin
                            best[mode] <= scoreNext;
                            new_best   <= 1'b1;
                        end else begin
                            new_best   <= 1'b0;
                        end
                    end
                end
                S_OVER: begin
                    if (start_pls) begin
                        state          <= S_IDLE;
                        ctrl_sig       <= CTRL_IDLE;
                        timer_reconfig <= 1'b1;
                        new_best       <= 1'b0;
                    end
                end
                S_LOGOUT: begin
                    log_out        <= 1'b0;
                    state          <= S_IDLE;
                    ctrl_sig       <= CTRL_IDLE;
                    timer_reconfig <= 1'b1;
                end
                S_TOP: begin
                    if (load_pls) begin
                        state          <= S_IDLE;
                        ctrl_sig       <= CTRL_IDLE;
                        timer_reconfig <= 1'b1;
                    end else if (start_pls) begin
                        page     <= ~page;
                        ctrl_sig <= page ? CTRL_TOP0 : CTRL_TOP1;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    ctrl_sig       <= CTRL_IDLE;
                    timer_en       <= 1'b0;
                    timer_reconfig <= 1'b1;
                    log_out        <= 1'b0;
                end
            endcase
        end
    end

    // Best-score readout: table entry for the page in the top-score view, else for the mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_bcd <= '0;
        end else if (state == S_TOP) begin
            best_bcd <= best[pageIdx];
        end else begin
            best_bcd <= best[mode];
        end
    end

    // Scramble/flip pulses and swap indices mirrored only while a round is running.
    always_ff @(posedge clk) begin
        if (rst || state != S_PLAY) begin
            scram_pls <= 1'b0;
            flip_pls  <= 1'b0;
            ind_out1  <= '0;
            ind_out2  <= '0;
        end else begin
            scram_pls <= start_pls;
            flip_pls  <= load_pls;
            ind_out1  <= ind_in1;
            ind_out2  <= ind_in2;
        end
    end

endmodule

// File: tb/tb_game_controller_gen.sv
// Directed bench for game_controller_gen with default parameters
// (3 modes, 2 BCD digits, mode display offset 4).
module tb_game_controller_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       log_on = 1'b0, pwd_pls = 1'b0, start_pls = 1'b0, load_pls = 1'b0;
    logic       is_correct = 1'b0, time_out = 1'b0, is_guest_in = 1'b0;
    logic [2:0] pid_in = '0, ind_in1 = '0, ind_in2 = '0;
    logic [2:0] ctrl_sig;
    logic       log_out, is_guest_out, new_best, scram_pls, flip_pls, timer_en, timer_reconfig;
    logic [2:0] pid_out, ind_out1, ind_out2;
    logic [7:0] score_bcd, best_bcd;
    logic [1:0] lett_num;
    logic [3:0] mode_disp;

    int checks = 0;
    int failures = 0;

    game_controller_gen dut (
        .clk(clk), .rst(rst), .log_on(log_on), .pwd_pls(pwd_pls), .start_pls(start_pls),
        .load_pls(load_pls), .is_correct(is_correct), .time_out(time_out), .pid_in(pid_in),
        .is_guest_in(is_guest_in), .ind_in1(ind_in1), .ind_in2(ind_in2), .ctrl_sig(ctrl_sig),
        .log_out(log_out), .pid_out(pid_out), .is_guest_out(is_guest_out), .score_bcd(score_bcd),
        .best_bcd(best_bcd), .new_best(new_best), .lett_num(lett_num), .mode_disp(mode_disp),
        .scram_pls(scram_pls), .flip_pls(flip_pls), .ind_out1(ind_out1), .ind_out2(ind_out2),
        .timer_en(timer_en), .timer_reconfig(timer_reconfig)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start_pls = 1'b1; tick(); start_pls = 1'b0;
    endtask

    task automatic pulseLoad();
        load_pls = 1'b1; tick(); load_pls = 1'b0;
    endtask

    task automatic pulseCorrect(input int n);
        for (int i = 0; i < n; i++) begin
            is_correct = 1'b1; tick(); is_correct = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        checks++; if (ctrl_sig !== 3'd0) begin failures++; $display("FAIL rst_ctrl got=%0d exp=0", ctrl_sig); end
        checks++; if (timer_reconfig !== 1'b1) begin failures++; $display("FAIL rst_reconfig got=%0b exp=1", timer_reconfig); end
        checks++; if (score_bcd !== 8'h00) begin failures++; $display("FAIL rst_score got=%0h exp=0", score_bcd); end
        checks++; if ({timer_en, log_out, new_best, scram_pls, mode_disp} !== 8'h00) begin failures++; $display("FAIL rst_outs got=%0h exp=0", {timer_en, log_out, new_best, scram_pls, mode_disp}); end
        rst = 1'b0; tick();
        checks++; if (ctrl_sig !== 3'd0) begin failures++; $display("FAIL rst_idle got=%0d exp=0", ctrl_sig); end
    endtask

    task automatic test_reset_midgame();
        log_on = 1'b1; tick();
        checks++; if (ctrl_sig !== 3'd1) begin failures++; $display("FAIL mid_setup got=%0d exp=1", ctrl_sig); end
        pulseStart();
        checks++; if (ctrl_sig !== 3'd2 || timer_en !== 1'b1) begin failures++; $display("FAIL mid_play got=%0d/%0b exp=2/1", ctrl_sig, timer_en); end
        pulseCorrect(7);
        checks++; if (score_bcd !== 8'h07) begin failures++; $display("FAIL mid_score7 got=%0h exp=07", score_bcd); end
        rst = 1'b1; tick(); rst = 1'b0; log_on = 1'b0;
        checks++; if (ctrl_sig !== 3'd0) begin failures++; $display("FAIL mid_rst_ctrl got=%0d exp=0", ctrl_sig); end
        checks++; if (score_bcd !== 8'h00) begin failures++; $display("FAIL mid_rst_score got=%0h exp=00", score_bcd); end
        checks++; if (timer_reconfig !== 1'b1 || timer_en !== 1'b0) begin failures++; $display("FAIL mid_rst_timer got=%0b/%0b exp=1/0", timer_reconfig, timer_en); end
        checks++; if (best_bcd !== 8'h00) begin failures++; $display("FAIL mid_rst_best got=%0h exp=00", best_bcd); end
        tick();
    endtask

    task automatic test_mode_cycle();
        log_on = 1'b1; tick();
        checks++; if (mode_disp !== 4'd4) begin failures++; $display("FAIL mode_disp0 got=%0d exp=4", mode_disp); end
        pulseLoad();
        checks++; if (mode_disp !== 4'd5) begin failures++; $display("FAIL mode_disp1 got=%0d exp=5", mode_disp); end
        pulseLoad();
        checks++; if (mode_disp !== 4'd6) begin failures++; $display("FAIL mode_disp2 got=%0d exp=6", mode_disp); end
        pulseLoad();
        checks++; if (ctrl_sig !== 3'd4 || mode_disp !== 4'd4) begin failures++; $display("FAIL mode_wrap got=%0d/%0d exp=4/4", ctrl_sig, mode_disp); end
        pulseStart();
        checks++; if (ctrl_sig !== 3'd5) begin failures++; $display("FAIL top_page1 got=%0d exp=5", ctrl_sig); end
        pulseStart();
        checks++; if (ctrl_sig !== 3'd4) begin failures++; $display("FAIL top_page0 got=%0d exp=4", ctrl_sig); end
        log_on = 1'b0; pulseLoad();
        checks++; if (ctrl_sig !== 3'd0 || timer_reconfig !== 1'b1) begin failures++; $display("FAIL top_exit got=%0d/%0b exp=0/1", ctrl_sig, timer_reconfig); end
    endtask

    task automatic test_score_saturate();
        log_on = 1'b1; tick(); pulseStart();
        checks++; if (lett_num !== 2'd0) begin failures++; $display("FAIL sat_lett got=%0d exp=0", lett_num); end
        start_pls = 1'b1; ind_in1 = 3'd5; ind_in2 = 3'd2; tick();
        start_pls = 1'b0; ind_in1 = 3'd0; ind_in2 = 3'd0;
        checks++; if ({scram_pls, ind_out1, ind_out2} !== {1'b1, 3'd5, 3'd2}) begin failures++; $display("FAIL mirror_on got=%0b/%0d/%0d exp=1/5/2", scram_pls, ind_out1, ind_out2); end
        tick();
        checks++; if (scram_pls !== 1'b0 || ctrl_sig !== 3'd2) begin failures++; $display("FAIL mirror_off got=%0b/%0d exp=0/2", scram_pls, ctrl_sig); end
        pulseCorrect(12);
        checks++; if (score_bcd !== 8'h12) begin failures++; $display("FAIL sat_12 got=%0h exp=12", score_bcd); end
        pulseCorrect(87);
        checks++; if (score_bcd !== 8'h99) begin failures++; $display("FAIL sat_99 got=%0h exp=99", score_bcd); end
        pulseCorrect(1);
        checks++; if (score_bcd !== 8'h99) begin failures++; $display("FAIL sat_hold got=%0h exp=99", score_bcd); end
        time_out = 1'b1; tick(); time_out = 1'b0;
        checks++; if (ctrl_sig !== 3'd3 || new_best !== 1'b1 || timer_en !== 1'b0) begin failures++; $display("FAIL sat_over got=%0d/%0b/%0b exp=3/1/0", ctrl_sig, new_best, timer_en); end
        tick();
        checks++; if (best_bcd !== 8'h99) begin failures++; $display("FAIL sat_best got=%0h exp=99", best_bcd); end
        log_on = 1'b0; pulseStart();
        checks++; if (ctrl_sig !== 3'd0) begin failures++; $display("FAIL sat_exit got=%0d exp=0", ctrl_sig); end
    endtask

    task automatic test_simultaneous();
        pid_in = 3'd5; is_guest_in = 1'b0;
        log_on = 1'b1; tick(); pulseLoad(); pulseStart();
        checks++; if (lett_num !== 2'd1) begin failures++; $display("FAIL sim_lett got=%0d exp=1", lett_num); end
        pulseCorrect(9);
        checks++; if (score_bcd !== 8'h09) begin failures++; $display("FAIL sim_09 got=%0h exp=09", score_bcd); end
        is_correct = 1'b1; time_out = 1'b1; tick(); is_correct = 1'b0; time_out = 1'b0;
        checks++; if (ctrl_sig !== 3'd3 || score_bcd !== 8'h10) begin failures++; $display("FAIL sim_over got=%0d/%0h exp=3/10", ctrl_sig, score_bcd); end
        checks++; if (new_best !== 1'b1 || pid_out !== 3'd5 || is_guest_out !== 1'b0) begin failures++; $display("FAIL sim_latch got=%0b/%0d/%0b exp=1/5/0", new_best, pid_out, is_guest_out); end
        tick();
        checks++; if (best_bcd !== 8'h10) begin failures++; $display("FAIL sim_best got=%0h exp=10", best_bcd); end
        log_on = 1'b0; pulseStart();
    endtask

    task automatic test_guest();
        pid_in = 3'd3; is_guest_in = 1'b1;
        log_on = 1'b1; tick(); pulseLoad(); pulseStart();
        pulseCorrect(20);
        checks++; if (score_bcd !== 8'h20) begin failures++; $display("FAIL guest_20 got=%0h exp=20", score_bcd); end
        time_out = 1'b1; tick(); time_out = 1'b0;
        checks++; if (new_best !== 1'b0 || is_guest_out !== 1'b1 || pid_out !== 3'd3) begin failures++; $display("FAIL guest_latch got=%0b/%0b/%0d exp=0/1/3", new_best, is_guest_out, pid_out); end
        tick();
        checks++; if (best_bcd !== 8'h10) begin failures++; $display("FAIL guest_best got=%0h exp=10", best_bcd); end
        log_on = 1'b0; is_guest_in = 1'b0; pulseStart();
    endtask

    task automatic test_topscore();
        log_on = 1'b1; tick(); pulseLoad(); pulseLoad(); pulseLoad();
        tick();
        checks++; if (ctrl_sig !== 3'd4 || best_bcd !== 8'h99) begin failures++; $display("FAIL top0_best got=%0d/%0h exp=4/99", ctrl_sig, best_bcd); end
        pulseStart(); tick();
        checks++; if (ctrl_sig !== 3'd5 || best_bcd !== 8'h10) begin failures++; $display("FAIL top1_best got=%0d/%0h exp=5/10", ctrl_sig, best_bcd); end
        log_on = 1'b0; pulseLoad();
    endtask

    task automatic test_logout();
        log_on = 1'b1; tick();
        pwd_pls = 1'b1; load_pls = 1'b1; tick(); pwd_pls = 1'b0; load_pls = 1'b0; log_on = 1'b0;
        checks++; if (log_out !== 1'b1 || mode_disp !== 4'd4 || timer_reconfig !== 1'b0) begin failures++; $display("FAIL lo_strobe got=%0b/%0d/%0b exp=1/4/0", log_out, mode_disp, timer_reconfig); end
        tick();
        checks++; if (log_out !== 1'b0 || timer_reconfig !== 1'b1 || ctrl_sig !== 3'd0) begin failures++; $display("FAIL lo_idle got=%0b/%0b/%0d exp=0/1/0", log_out, timer_reconfig, ctrl_sig); end
        tick();
        checks++; if (log_out !== 1'b0 || ctrl_sig !== 3'd0) begin failures++; $display("FAIL lo_stay got=%0b/%0d exp=0/0", log_out, ctrl_sig); end
    endtask

    initial begin
        test_reset();
        test_reset_midgame();
        test_mode_cycle();
        test_score_saturate();
        test_simultaneous();
        test_guest();
        test_topscore();
        test_logout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
